// File: rtl/l2_req_arbiter.sv
// l2_req_arbiter: round-robin arbiter that forwards one source request at a
// time to the L2 core. It routes the single outstanding response back to the
// granted source. A watchdog synthesises an error response if L2 stays silent.
module l2_req_arbiter #(
  parameter int CHAN_COUNT = 5,
  parameter int ADDR_W     = 48,
  parameter int LINE_W     = 256,
  parameter int TIMEOUT    = 1023,
  localparam int SRC_W     = (CHAN_COUNT > 1) ? $clog2(CHAN_COUNT) : 1,
  localparam int STRB_W    = LINE_W / 8
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [CHAN_COUNT-1:0]        i_req_valid,
  input  logic [CHAN_COUNT-1:0]        i_req_write,
  input  logic [CHAN_COUNT*ADDR_W-1:0] i_req_addr,
  input  logic [CHAN_COUNT*LINE_W-1:0] i_req_wdata,
  input  logic [CHAN_COUNT*STRB_W-1:0] i_req_wstrb,
  output logic [CHAN_COUNT-1:0]        o_req_ready,
  output logic                         o_l2_req_valid,
  input  logic                         i_l2_req_ready,
  output logic [SRC_W-1:0]             o_l2_req_src,
  output logic                         o_l2_req_write,
  output logic [ADDR_W-1:0]            o_l2_req_addr,
  output logic [LINE_W-1:0]            o_l2_req_wdata,
  output logic [STRB_W-1:0]            o_l2_req_wstrb,
  input  logic                         i_l2_resp_valid,
  input  logic [LINE_W-1:0]            i_l2_resp_rdata,
  input  logic                         i_l2_resp_err,
  output logic [CHAN_COUNT-1:0]        o_resp_valid,
  output logic [LINE_W-1:0]            o_resp_rdata,
  output logic                         o_resp_err,
  output logic                         o_timeout
);
  // The counter is sized to hold TIMEOUT-1. A width of 1 when the watchdog is disabled avoids a zero-width vector.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RESP, RESP} state_t;

  state_t              r_state, w_next;
  logic [SRC_W-1:0]    r_last, r_src;
  logic                r_write, r_err, r_timeout;
  logic [ADDR_W-1:0]   r_addr;
  logic [LINE_W-1:0]   r_wdata, r_rdata;
  logic [STRB_W-1:0]   r_wstrb;
  logic [CNT_W-1:0]    r_cnt;

  logic [SRC_W:0]      w_start, w_off, w_sum;
  logic [CHAN_COUNT-1:0] w_rot;
  logic                w_grant_found;
  logic [SRC_W-1:0]    w_grant_idx;
  logic                w_sel_write;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [LINE_W-1:0]   w_sel_wdata;
  logic [STRB_W-1:0]   w_sel_wstrb;
  logic                w_expire;

  // Rotate the valids so that bit 0 is the channel after last_grant. The first set bit is then the grant.
  always_comb begin
    w_start       = {1'b0, r_last} + (SRC_W+1)'(1);
    w_rot         = CHAN_COUNT'({i_req_valid, i_req_valid} >> w_start);
    w_off         = '0;
    for (int i = CHAN_COUNT - 1; i >= 0; i--)
      if (w_rot[i]) w_off = (SRC_W+1)'(i);
    w_sum         = w_start + w_off;
    if (w_sum >= (SRC_W+1)'(CHAN_COUNT)) w_sum = w_sum - (SRC_W+1)'(CHAN_COUNT);
    w_grant_idx   = w_sum[SRC_W-1:0];
    w_grant_found = |i_req_valid;
  end

  // Select the granted channel's request fields.
  always_comb begin
    w_sel_write = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    w_sel_wstrb = '0;
    for (int k = 0; k < CHAN_COUNT; k++) begin
      if (w_grant_idx == SRC_W'(k)) begin
        w_sel_write = i_req_write[k];
        w_sel_addr  = i_req_addr[k*ADDR_W +: ADDR_W];
        w_sel_wdata = i_req_wdata[k*LINE_W +: LINE_W];
        w_sel_wstrb = i_req_wstrb[k*STRB_W +: STRB_W];
      end
    end
  end

  assign w_expire = (TIMEOUT != 0) && (r_cnt == CNT_W'(TIMEOUT - 1));

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next state and per-state strobes. A response in the expiry cycle wins over the watchdog.
  always_comb begin
    w_next         = r_state;
    o_req_ready    = '0;
    o_l2_req_valid = 1'b0;
    o_resp_valid   = '0;
    case (r_state)
      IDLE: if (w_grant_found) begin
        o_req_ready = CHAN_COUNT'(1) << w_grant_idx;
        w_next      = REQ;
      end
      REQ: begin
        o_l2_req_valid = 1'b1;
        if (i_l2_req_ready) w_next = WAIT_RESP;
      end
      WAIT_RESP: if (i_l2_resp_valid || w_expire) w_next = RESP;
      RESP: begin
        o_resp_valid = CHAN_COUNT'(1) << r_src;
        w_next       = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Request latch, grant history, watchdog and response capture.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last    <= SRC_W'(CHAN_COUNT - 1);
      r_src     <= '0;
      r_write   <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
      r_timeout <= 1'b0;
      r_cnt     <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_grant_found) begin
          r_src   <= w_grant_idx;
          r_last  <= w_grant_idx;
          r_write <= w_sel_write;
          r_addr  <= w_sel_addr;
          r_wdata <= w_sel_wdata;
          r_wstrb <= w_sel_wstrb;
        end
        REQ: if (i_l2_req_ready) r_cnt <= '0;
        WAIT_RESP: begin
          if (i_l2_resp_valid) begin
            r_rdata <= i_l2_resp_rdata;
            r_err   <= i_l2_resp_err;
          end else if (w_expire) begin
            r_rdata   <= '0;
            r_err     <= 1'b1;
            r_timeout <= 1'b1;
          end else if (TIMEOUT != 0) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign o_l2_req_src   = r_src;
  assign o_l2_req_write = r_write;
  assign o_l2_req_addr  = r_addr;
  assign o_l2_req_wdata = r_wdata;
  assign o_l2_req_wstrb = r_wstrb;
  assign o_resp_rdata   = r_rdata;
  assign o_resp_err     = r_err;
  assign o_timeout      = r_timeout;
endmodule

// File: tb/tb_l2_req_arbiter.sv
// Bench for l2_req_arbiter: directed scenarios with literal expectations plus
// randomized traffic. A transaction-level reference model is checked every cycle.
module tb_l2_req_arbiter;
  localparam int N = 5, AW = 48, LW = 64, SB = LW / 8, TO = 16, SW = 3;
  localparam int P_OPEN = 0, P_ISSUE = 1, P_WAIT = 2, P_DELIVER = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [N-1:0]    req_valid, req_write, req_ready, resp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*LW-1:0] req_wdata;
  logic [N*SB-1:0] req_wstrb;
  logic            l2_valid, l2_ready, l2_write, l2_resp_valid, l2_resp_err, resp_err, timeout;
  logic [SW-1:0]   l2_src;
  logic [AW-1:0]   l2_addr;
  logic [LW-1:0]   l2_wdata, l2_resp_rdata, resp_rdata;
  logic [SB-1:0]   l2_wstrb;

  l2_req_arbiter #(.CHAN_COUNT(N), .ADDR_W(AW), .LINE_W(LW), .TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid), .i_req_write(req_write), .i_req_addr(req_addr),
    .i_req_wdata(req_wdata), .i_req_wstrb(req_wstrb), .o_req_ready(req_ready),
    .o_l2_req_valid(l2_valid), .i_l2_req_ready(l2_ready), .o_l2_req_src(l2_src),
    .o_l2_req_write(l2_write), .o_l2_req_addr(l2_addr), .o_l2_req_wdata(l2_wdata),
    .o_l2_req_wstrb(l2_wstrb), .i_l2_resp_valid(l2_resp_valid),
    .i_l2_resp_rdata(l2_resp_rdata), .i_l2_resp_err(l2_resp_err),
    .o_resp_valid(resp_valid), .o_resp_rdata(resp_rdata), .o_resp_err(resp_err),
    .o_timeout(timeout));

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h, want %0h", nm, $time, act, exp);
    end
  endtask

  // The nearest set channel after 'last' in circular order is granted.
  function automatic int rr_pick(input logic [N-1:0] v, input int last);
    int best, bd, d;
    best = -1; bd = N;
    for (int c = 0; c < N; c++) begin
      d = (c - last - 1 + 2 * N) % N;
      if (v[c] && d < bd) begin bd = d; best = c; end
    end
    return best;
  endfunction

  // Reference model: one transaction record that advances through the phases open/issue/wait/deliver.
  int            m_phase, m_last, m_src, m_waited, pick;
  logic          m_write, m_err, m_timeout;
  logic [AW-1:0] m_addr;
  logic [LW-1:0] m_wdata, m_rdata;
  logic [SB-1:0] m_wstrb;
  logic [N-1:0]  exp_rdy, exp_rv;

  initial begin
    m_phase = P_OPEN; m_last = N - 1; m_src = 0; m_waited = 0; m_timeout = 1'b0;
    m_write = 1'b0; m_err = 1'b0; m_addr = '0; m_wdata = '0; m_rdata = '0; m_wstrb = '0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      pick = (m_phase == P_OPEN) ? rr_pick(req_valid, m_last) : -1;
      exp_rdy = '0;
      if (pick >= 0) exp_rdy[pick] = 1'b1;
      chk("m_req_ready", req_ready, exp_rdy);
      chk("m_l2_valid", l2_valid, m_phase == P_ISSUE);
      if (m_phase == P_ISSUE) begin
        chk("m_src", l2_src, m_src);
        chk("m_write", l2_write, m_write);
        chk("m_addr", l2_addr, m_addr);
        chk("m_wdata", l2_wdata, m_wdata);
        chk("m_wstrb", l2_wstrb, m_wstrb);
      end
      exp_rv = '0;
      if (m_phase == P_DELIVER) exp_rv[m_src] = 1'b1;
      chk("m_resp_valid", resp_valid, exp_rv);
      if (m_phase == P_DELIVER) begin
        chk("m_rdata", resp_rdata, m_rdata);
        chk("m_err", resp_err, m_err);
      end
      chk("m_timeout", timeout, m_timeout);
      if (rst) begin
        m_phase = P_OPEN; m_last = N - 1; m_timeout = 1'b0;
      end else begin
        case (m_phase)
          P_OPEN: if (pick >= 0) begin
            m_src = pick; m_last = pick; m_write = req_write[pick];
            for (int c = 0; c < N; c++)
              if (c == pick) begin
                m_addr  = req_addr[c*AW +: AW];
                m_wdata = req_wdata[c*LW +: LW];
                m_wstrb = req_wstrb[c*SB +: SB];
              end
            m_phase = P_ISSUE;
          end
          P_ISSUE: if (l2_ready) begin m_phase = P_WAIT; m_waited = 0; end
          P_WAIT: begin
            m_waited++;
            if (l2_resp_valid) begin
              m_rdata = l2_resp_rdata; m_err = l2_resp_err; m_phase = P_DELIVER;
            end else if (TO != 0 && m_waited >= TO) begin
              m_rdata = '0; m_err = 1'b1; m_timeout = 1'b1; m_phase = P_DELIVER;
            end
          end
          default: m_phase = P_OPEN;
        endcase
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_time_limit reached @%0t", $time);
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_req(input int c, input logic w, input logic [AW-1:0] a,
                         input logic [LW-1:0] d, input logic [SB-1:0] s);
    req_valid[c] = 1'b1; req_write[c] = w;
    req_addr[c*AW +: AW] = a; req_wdata[c*LW +: LW] = d; req_wstrb[c*SB +: SB] = s;
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
  endtask

  int grants[10];
  int ng, rdy, stab, first, extra;
  logic [N-1:0] acc, wd_vec;
  logic wd_err, wd_to, silent;
  logic [LW-1:0] wd_rdata;

  initial begin
    rst = 1'b1; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    l2_ready = 1'b0; l2_resp_valid = 1'b0; l2_resp_rdata = '0; l2_resp_err = 1'b0; silent = 1'b0;
    tick(); tick(); rst = 1'b0;
    @(negedge clk);
    chk("rst_l2_valid", l2_valid, 0);
    chk("rst_addr", l2_addr, 0);
    chk("rst_src", l2_src, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_rdata", resp_rdata, 0);
    chk("rst_timeout", timeout, 0);

    // Single read from ch2. L2 answers in the third wait cycle.
    tick(); set_req(2, 1'b0, 48'h8000_1000, 64'h0, 8'h00);
    @(negedge clk); chk("t1_ready", req_ready, 5'b00100);
    tick(); req_valid[2] = 1'b0; l2_ready = 1'b1;
    @(negedge clk);
    chk("t1_l2_valid", l2_valid, 1);
    chk("t1_src", l2_src, 2);
    chk("t1_addr", l2_addr, 48'h8000_1000);
    tick(); l2_ready = 1'b0;
    tick();
    tick(); l2_resp_valid = 1'b1; l2_resp_rdata = 64'hA5A5_A5A5_A5A5_A5A5; l2_resp_err = 1'b0;
    tick(); l2_resp_valid = 1'b0;
    @(negedge clk);
    chk("t1_resp_valid", resp_valid, 5'b00100);
    chk("t1_rdata", resp_rdata, 64'hA5A5_A5A5_A5A5_A5A5);
    chk("t1_err", resp_err, 0);
    tick(); @(negedge clk); chk("t1_resp_once", resp_valid, 0);

    // Fairness: all channels permanently requesting.
    do_reset();
    for (int c = 0; c < N; c++) set_req(c, c[0], 48'(32'h1000 * c), {$urandom(), $urandom()}, 8'hFF);
    l2_ready = 1'b1; l2_resp_valid = 1'b1; l2_resp_rdata = 64'h1111_2222_3333_4444;
    ng = 0;
    for (int cyc = 0; cyc < 80 && ng < 10; cyc++) begin
      @(negedge clk); acc = req_ready;
      for (int c = 0; c < N; c++) if (acc[c] && ng < 10) begin grants[ng] = c; ng++; end
      tick();
      for (int c = 0; c < N; c++)
        if (acc[c]) set_req(c, $urandom_range(0, 1) == 1, 48'({$urandom(), $urandom()}), {$urandom(), $urandom()}, 8'($urandom()));
    end
    chk("fair_count", ng, 10);
    for (int i = 0; i < 10; i++) chk($sformatf("fair_grant%0d", i), grants[i], i % N);
    req_valid = '0;
    repeat (6) tick();
    l2_resp_valid = 1'b0; l2_ready = 1'b0;

    // Backpressure: seven cycles without L2 ready.
    set_req(1, 1'b1, 48'hABCD_0040, 64'hDEAD_BEEF_0123_4567, 8'h3C);
    rdy = 0; stab = 0;
    @(negedge clk); rdy += int'(req_ready[1]);
    for (int i = 0; i < 8; i++) begin
      tick(); if (i == 0) req_valid[1] = 1'b0; l2_ready = (i == 7);
      @(negedge clk); rdy += int'(req_ready[1]);
      if (l2_valid && l2_write && l2_addr == 48'hABCD_0040 && l2_wdata == 64'hDEAD_BEEF_0123_4567 && l2_wstrb == 8'h3C) stab++;
    end
    tick(); l2_ready = 1'b0; l2_resp_valid = 1'b1; l2_resp_rdata = 64'h77;
    tick(); l2_resp_valid = 1'b0;
    tick();
    chk("bp_stable_cycles", stab, 8);
    chk("bp_ready_pulses", rdy, 1);

    // Watchdog expiry and a late response afterwards.
    set_req(3, 1'b0, 48'h0000_3000, 64'h0, 8'h00); l2_ready = 1'b1;
    @(negedge clk);
    tick(); req_valid[3] = 1'b0;
    first = -1; extra = 0;
    for (int k = 1; k <= 26; k++) begin
      tick(); l2_ready = 1'b0; l2_resp_valid = (k == 22); l2_resp_rdata = 64'hFFFF_0000_FFFF_0000; l2_resp_err = 1'b0;
      @(negedge clk);
      if (resp_valid != '0) begin
        if (first < 0) begin
          first = k; wd_vec = resp_valid; wd_err = resp_err; wd_rdata = resp_rdata; wd_to = timeout;
        end else extra++;
      end
    end
    tick(); l2_resp_valid = 1'b0;
    chk("wd_first_cycle", first, 17);
    chk("wd_vec", wd_vec, 5'b01000);
    chk("wd_err", wd_err, 1);
    chk("wd_rdata", wd_rdata, 0);
    chk("wd_timeout", wd_to, 1);
    chk("wd_late_ignored", extra, 0);

    // Response collides with the expiry cycle.
    do_reset();
    set_req(0, 1'b0, 48'h0000_0100, 64'h0, 8'h00); l2_ready = 1'b1;
    @(negedge clk);
    tick(); req_valid[0] = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      tick(); l2_ready = 1'b0; l2_resp_valid = (k == 16); l2_resp_rdata = 64'h0000_1234_5678_9ABC; l2_resp_err = 1'b0;
      @(negedge clk);
      if (k == 17) begin
        chk("col_resp_valid", resp_valid, 5'b00001);
        chk("col_err", resp_err, 0);
        chk("col_rdata", resp_rdata, 64'h0000_1234_5678_9ABC);
        chk("col_timeout", timeout, 0);
      end
    end
    tick(); l2_resp_valid = 1'b0;

    // Reset while waiting; a response during reset is dropped.
    set_req(1, 1'b0, 48'h0000_0200, 64'h0, 8'h00); l2_ready = 1'b1;
    @(negedge clk);
    tick(); req_valid[1] = 1'b0;
    tick(); l2_ready = 1'b0;
    tick();
    tick(); rst = 1'b1; l2_resp_valid = 1'b1; l2_resp_rdata = 64'h55;
    tick(); rst = 1'b0; l2_resp_valid = 1'b0;
    @(negedge clk);
    chk("rw_l2_valid", l2_valid, 0);
    chk("rw_resp_valid", resp_valid, 0);
    chk("rw_src", l2_src, 0);
    chk("rw_addr", l2_addr, 0);
    chk("rw_rdata", resp_rdata, 0);
    chk("rw_err", resp_err, 0);
    chk("rw_ready", req_ready, 0);
    tick(); set_req(4, 1'b1, 48'h0000_0400, 64'h99, 8'h01);
    @(negedge clk); chk("rw_ch4_ready", req_ready, 5'b10000);
    tick(); req_valid[4] = 1'b0; l2_ready = 1'b1;
    @(negedge clk); chk("rw_ch4_src", l2_src, 4);
    tick(); l2_ready = 1'b0; l2_resp_valid = 1'b1;
    tick(); l2_resp_valid = 1'b0;
    tick();

    // Randomized traffic; the model process checks every cycle.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk); acc = req_ready;
      tick();
      for (int c = 0; c < N; c++) begin
        if (req_valid[c] && acc[c]) req_valid[c] = 1'b0;
        if (!req_valid[c] && $urandom_range(0, 3) == 0)
          set_req(c, $urandom_range(0, 1) == 1, 48'({$urandom(), $urandom()}), {$urandom(), $urandom()}, 8'($urandom()));
        else if (req_valid[c] && $urandom_range(0, 63) == 0)
          req_valid[c] = 1'b0;
      end
      if (cyc % 256 == 0) silent = ($urandom_range(0, 2) == 0);
      l2_ready      = $urandom_range(0, 1) == 1;
      l2_resp_valid = !silent && ($urandom_range(0, 3) == 0);
      l2_resp_rdata = {$urandom(), $urandom()};
      l2_resp_err   = $urandom_range(0, 7) == 0;
      rst           = $urandom_range(0, 399) == 0;
    end
    rst = 1'b0;
    tick();
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
